// File: rtl/systolic_job_sequencer.sv
// systolic_job_sequencer: runs one job on the NxN bit-level systolic array.
// Pairs an operand byte stream into (in1, in2) beats, flushes the array with
// N zero beats, then drains the accumulator rows (N-1 down to 0) through a
// registered valid/ready result port.
module systolic_job_sequencer #(
  parameter int N  = 8,
  parameter int LW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_xor,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          arr_clear,
  output logic          arr_valid,
  output logic          arr_readout,
  output logic          arr_usexor,
  output logic [N-1:0]  arr_in1,
  output logic [N-1:0]  arr_in2,
  input  logic [N-1:0]  arr_out,
  output logic          res_valid,
  output logic [N-1:0]  res_data,
  output logic [RW-1:0] res_row,
  input  logic          res_ready
);

  // Counters must reach N (flush) and N+1 (readout pulses done).
  localparam int CW = $clog2(N + 2);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_READ, S_DONE} state_t;

  state_t        state_q;
  logic [LW-1:0] len_q, pairs_q;
  logic          phase_q;
  logic [N-1:0]  hold_q;
  logic [CW-1:0] fcnt_q, pcnt_q;
  logic          busy_q, done_q, in_ready_q, clear_q, arr_valid_q, usexor_q, res_valid_q;
  logic [N-1:0]  in1_q, in2_q, res_data_q;
  logic [RW-1:0] res_row_q;

  logic take, pulse, last_pair;

  assign take      = in_valid & in_ready_q;
  // A readout pulse only fires when the result register can take a row, so a
  // stalled consumer freezes the array (readout=0, valid=0 hold its state).
  assign pulse     = (state_q == S_READ) && (pcnt_q <= CW'(N)) && (!res_valid_q || res_ready);
  assign last_pair = (pairs_q + LW'(1)) == len_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign in_ready    = in_ready_q;
  assign arr_clear   = clear_q | reset;
  assign arr_valid   = arr_valid_q;
  assign arr_readout = pulse;
  assign arr_usexor  = usexor_q;
  assign arr_in1     = in1_q;
  assign arr_in2     = in2_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_row     = res_row_q;

  // Job FSM with registered array controls, operand pairing and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pairs_q     <= '0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      fcnt_q      <= '0;
      pcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      clear_q     <= 1'b0;
      arr_valid_q <= 1'b0;
      usexor_q    <= 1'b0;
      res_valid_q <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      res_data_q  <= '0;
      res_row_q   <= '0;
    end else begin
      // Single-cycle strobes and operand buses default low.
      arr_valid_q <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          len_q    <= cfg_len;
          usexor_q <= cfg_xor;
          busy_q   <= 1'b1;
          clear_q  <= 1'b1;
          state_q  <= S_CLEAR;
        end
        S_CLEAR: begin
          phase_q <= 1'b0;
          pairs_q <= '0;
          fcnt_q  <= '0;
          if (len_q == '0) state_q <= S_FLUSH;
          else begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end
        end
        S_LOAD: if (take) begin
          if (!phase_q) begin
            hold_q  <= in_data;
            phase_q <= 1'b1;
          end else begin
            phase_q     <= 1'b0;
            arr_valid_q <= 1'b1;
            in1_q       <= hold_q;
            in2_q       <= in_data;
            pairs_q     <= pairs_q + LW'(1);
            // Stop accepting as the final pair issues; flush starts behind it.
            if (last_pair) begin
              in_ready_q <= 1'b0;
              state_q    <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (fcnt_q == CW'(N)) begin
            state_q <= S_READ;
            pcnt_q  <= '0;
          end else begin
            arr_valid_q <= 1'b1;
            fcnt_q      <= fcnt_q + CW'(1);
          end
        end
        S_READ: begin
          if (pulse) pcnt_q <= pcnt_q + CW'(1);
          // Pulse 0 only exposes the flushed zeros; later pulses carry row N-p.
          if (pulse && pcnt_q != '0) begin
            res_data_q  <= arr_out;
            res_row_q   <= RW'(N - int'(pcnt_q));
            res_valid_q <= 1'b1;
          end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
          end
          if (pcnt_q == CW'(N + 1) && (!res_valid_q || res_ready)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// Bench for systolic_job_sequencer: contains a behavioural NxN bit-level
// systolic array (in1 bit i travels along row i, in2 bit j down column j,
// cells AND and accumulate) and drives whole jobs from a vector table.
module tb_systolic_job_sequencer;
  localparam int N = 8;

  logic       clk = 0, reset = 1, start = 0, cfg_xor = 0;
  logic [7:0] cfg_len = 0;
  logic       busy, done, in_valid = 0, in_ready;
  logic [7:0] in_data = 0;
  logic       arr_clear, arr_valid, arr_readout, arr_usexor;
  logic [7:0] arr_in1, arr_in2, arr_out, res_data;
  logic       res_valid, res_ready = 1;
  logic [2:0] res_row;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  systolic_job_sequencer #(.N(N), .LW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_xor(cfg_xor),
    .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .arr_clear(arr_clear), .arr_valid(arr_valid), .arr_readout(arr_readout),
    .arr_usexor(arr_usexor), .arr_in1(arr_in1), .arr_in2(arr_in2), .arr_out(arr_out),
    .res_valid(res_valid), .res_data(res_data), .res_row(res_row), .res_ready(res_ready)
  );

  // Array model: mh[i] bit j = in1 bit i at column j; mv[i] = in2 word at row i.
  logic [7:0] mh [8];
  logic [7:0] mv [8];
  logic [7:0] macc [8];
  logic [7:0] mout;
  assign arr_out = mout;

  always @(posedge clk) begin
    if (arr_clear) begin
      for (int i = 0; i < 8; i++) begin mh[i] <= '0; mv[i] <= '0; macc[i] <= '0; end
      mout <= '0;
    end else if (arr_valid) begin
      for (int i = 0; i < 8; i++) begin
        macc[i] <= arr_usexor ? (macc[i] ^ (mh[i] & mv[i])) : (macc[i] | (mh[i] & mv[i]));
        mh[i]   <= {mh[i][6:0], arr_in1[i]};
      end
      mv[0] <= arr_in2;
      for (int i = 1; i < 8; i++) mv[i] <= mv[i-1];
    end else if (arr_readout) begin
      mout    <= macc[7];
      for (int i = 1; i < 8; i++) macc[i] <= macc[i-1];
      macc[0] <= '0;
    end
  end

  typedef struct packed {
    logic [7:0]       len;
    logic             xr;
    logic             gaps;
    logic             stall;
    logic [3:0][7:0]  b;    // b[0] first byte
    logic [7:0][7:0]  exp;  // exp[r] = expected row r
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  task automatic run_job(input vec_t v, input string nm);
    int bi = 0, rows = 0, dn = 0, vcnt = 0, ccnt = 0, viol = 0, stl = 0;
    logic ordok = 1, xok = 1, irdy = 0, fin = 0;
    logic [7:0] got [8];
    for (int r = 0; r < 8; r++) got[r] = 'x;
    @(negedge clk);
    start = 1; cfg_len = v.len; cfg_xor = v.xr;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      start    = 0;
      in_valid = !v.gaps || cyc[0];
      in_data  = (bi < 2 * int'(v.len)) ? v.b[bi[1:0]] : 8'hEE;
      res_ready = !(v.stall && res_valid && rows == 3 && stl < 3);
      if (!res_ready) stl++;
      #1;
      if (dn > 0 && !done) begin
        chk({nm, " busy_after_done"}, 32'(busy), 32'd0);
        fin = 1;
      end else begin
        if (in_ready) irdy = 1;
        if (in_valid && in_ready) bi++;
        if (arr_valid) vcnt++;
        if (arr_clear) ccnt++;
        if (busy && arr_usexor !== v.xr) xok = 0;
        if (arr_readout && res_valid && !res_ready) viol++;
        if (res_valid && res_ready) begin
          if (32'(res_row) != 32'(7 - rows)) ordok = 0;
          got[res_row] = res_data;
          rows++;
        end
        if (done) dn++;
      end
    end
    in_valid = 0;
    res_ready = 1;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout got no completion want done", nm);
    end
    for (int r = 0; r < 8; r++) chk($sformatf("%s row%0d", nm, r), 32'(got[r]), 32'(v.exp[r]));
    chk({nm, " row_order"}, 32'(ordok), 32'd1);
    chk({nm, " row_count"}, 32'(rows), 32'd8);
    chk({nm, " bytes_taken"}, 32'(bi), 2 * 32'(v.len));
    chk({nm, " done_pulses"}, 32'(dn), 32'd1);
    chk({nm, " valid_beats"}, 32'(vcnt), 32'(v.len) + 32'(N));
    chk({nm, " clear_cycles"}, 32'(ccnt), 32'd1);
    chk({nm, " usexor"}, 32'(xok), 32'd1);
    chk({nm, " readout_in_stall"}, 32'(viol), 32'd0);
    if (v.len == 0) chk({nm, " in_ready_seen"}, 32'(irdy), 32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    int acc;
    logic [63:0] diag, xr2, or2;
    diag = 64'h80402010_08040201;
    xr2  = 64'h40A05028_140A0502;
    or2  = 64'hC0E07038_1C0E0703;
    vecs[0] = '{len:8'd1, xr:1'b0, gaps:1'b0, stall:1'b0, b:32'h0000_FFFF, exp:diag};
    vecs[1] = '{len:8'd1, xr:1'b0, gaps:1'b0, stall:1'b0, b:32'h0000_FF0F, exp:64'h00000000_08040201};
    vecs[2] = '{len:8'd2, xr:1'b1, gaps:1'b0, stall:1'b0, b:32'hFFFF_FFFF, exp:xr2};
    vecs[3] = '{len:8'd2, xr:1'b0, gaps:1'b0, stall:1'b0, b:32'hFFFF_FFFF, exp:or2};
    vecs[4] = '{len:8'd0, xr:1'b0, gaps:1'b0, stall:1'b0, b:32'h0, exp:64'h0};
    vecs[5] = '{len:8'd1, xr:1'b1, gaps:1'b0, stall:1'b0, b:32'h0000_FFAA, exp:64'h80002000_08000200};
    vecs[6] = '{len:8'd1, xr:1'b0, gaps:1'b0, stall:1'b0, b:32'h0000_F0FF, exp:64'h80402010_00000000};
    vecs[7] = '{len:8'd2, xr:1'b1, gaps:1'b1, stall:1'b1, b:32'hFFFF_FFFF, exp:xr2};
    vecs[8] = '{len:8'd2, xr:1'b0, gaps:1'b1, stall:1'b1, b:32'hFFFF_FFFF, exp:or2};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst arr_valid", 32'(arr_valid), 0);
    chk("rst res_valid", 32'(res_valid), 0);
    chk("rst arr_clear", 32'(arr_clear), 1);
    chk("rst buses", {arr_in1, arr_in2, res_data, 5'd0, res_row}, 0);
    reset = 0;
    @(negedge clk);
    chk("idle arr_clear", 32'(arr_clear), 0);
    chk("idle done", 32'(done), 0);

    for (int k = 0; k < 9; k++) run_job(vecs[k], $sformatf("vec%0d", k));

    // Reset during LOAD after three accepted bytes, then a clean job.
    @(negedge clk);
    start = 1; cfg_len = 8'd2; cfg_xor = 1;
    acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 3; cyc++) begin
      @(negedge clk);
      start = 0; in_valid = 1; in_data = 8'hFF;
      #1;
      if (in_ready) acc++;
    end
    chk("midrst bytes", 32'(acc), 3);
    @(negedge clk);
    in_valid = 0; reset = 1;
    #1;
    chk("midrst clear_now", 32'(arr_clear), 1);
    @(negedge clk);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    chk("midrst arr_valid", 32'(arr_valid), 0);
    chk("midrst usexor", 32'(arr_usexor), 0);
    chk("midrst buses", {arr_in1, arr_in2, res_data, 5'd0, res_row}, 0);
    chk("midrst clear", 32'(arr_clear), 1);
    reset = 0;
    @(negedge clk);
    chk("midrst idle busy", 32'(busy), 0);
    run_job(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
